fib_index_finder: RTL and testbench



---
 rtl/fib_pkg.sv | 14 +
 rtl/fib_term_step.sv | 35 +++
 rtl/fib_index_finder.sv | 93 +++++++++
 tb/tb_fib_index_finder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state encoding and seed terms for the Fibonacci datapath
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } fib_state_t;

  // Generator and finder must agree on F(0) and F(1).
  localparam int FIB_SEED0 = 1;
  localparam int FIB_SEED1 = 1;

endpackage

// File: rtl/fib_term_step.sv
// rtl/fib_term_step.sv - current/next Fibonacci term pair with seed load and saturating advance
module fib_term_step
  import fib_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         CLR,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] a,
  output logic [W-1:0] b
);

  logic [W:0]   sum;
  logic [W-1:0] sum_sat;

  // Clamp instead of wrapping so an oversized term always compares high.
  assign sum     = {1'b0, a} + {1'b0, b};
  assign sum_sat = sum[W] ? {W{1'b1}} : sum[W-1:0];

  always_ff @(posedge clk) begin
    if (CLR) begin
      a <= W'(FIB_SEED0);
      b <= W'(FIB_SEED1);
    end else if (load) begin
      a <= W'(FIB_SEED0);
      b <= W'(FIB_SEED1);
    end else if (advance) begin
      a <= b;
      b <= sum_sat;
    end
  end

endmodule

// File: rtl/fib_index_finder.sv
// rtl/fib_index_finder.sv - walks the Fibonacci sequence one term per clock to find the index of a value
module fib_index_finder
  import fib_pkg::*;
#(
  parameter int VW = 5,
  parameter int NW = 3
) (
  input  logic          clk,
  input  logic          CLR,
  input  logic          start,
  input  logic [VW-1:0] value,
  output logic [NW-1:0] n,
  output logic          found,
  output logic          done,
  output logic          busy
);

  localparam int AW = VW + 1;
  localparam logic [NW-1:0] IDX_MAX = {NW{1'b1}};

  fib_state_t    state;
  logic [VW-1:0] tgt;
  logic [NW-1:0] idx;
  logic [AW-1:0] a;
  logic [AW-1:0] b;
  logic          load;
  logic          advance;
  logic          hit;
  logic          over;

  assign hit     = (a == {1'b0, tgt});
  assign over    = (a > {1'b0, tgt}) || (idx == IDX_MAX);
  assign load    = (state == ST_IDLE) && start;
  assign advance = (state == ST_SEARCH) && !hit && !over;

  fib_term_step #(.W(AW)) u_step (
    .clk     (clk),
    .CLR     (CLR),
    .load    (load),
    .advance (advance),
    .a       (a),
    .b       (b)
  );

  always_ff @(posedge clk) begin
    if (CLR) begin
      state <= ST_IDLE;
      tgt   <= '0;
      idx   <= '0;
      n     <= '0;
      found <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            tgt   <= value;
            idx   <= '0;
            busy  <= 1'b1;
            found <= 1'b0;
            state <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          // A match wins over the range limit, so the last index can still hit.
          if (hit) begin
            n     <= idx;
            found <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else if (over) begin
            n     <= '0;
            found <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            idx <= idx + NW'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_index_finder.sv
// tb/tb_fib_index_finder.sv - self-checking bench for fib_index_finder
module tb_fib_index_finder;

  logic       clk;
  logic       CLR;
  logic       start;
  logic [4:0] value;
  logic [2:0] n;
  logic       found;
  logic       done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  fib_index_finder #(.VW(5), .NW(3)) dut (
    .clk   (clk),
    .CLR   (CLR),
    .start (start),
    .value (value),
    .n     (n),
    .found (found),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v;
    int en;
    int ef;
    int elat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: list the terms by plain addition and scan for the value.
  function automatic void ref_model(input int v, output int en, output int ef, output int elat);
    int  f[8];
    bit  fin;
    f[0] = 1;
    f[1] = 1;
    for (int i = 2; i < 8; i++) f[i] = f[i-1] + f[i-2];
    en = 0; ef = 0; elat = 8; fin = 0;
    for (int i = 0; i < 8; i++) begin
      if (!fin) begin
        if (f[i] == v) begin
          en = i; ef = 1; elat = i + 1; fin = 1;
        end else if (f[i] > v) begin
          elat = i + 1; fin = 1;
        end
      end
    end
  endfunction

  task automatic wait_done(output int c);
    c = 0;
    while (c < 20) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (done) break;
    end
  endtask

  task automatic do_search(input int v, input int en, input int ef, input int elat, input string tag);
    int c;
    @(negedge clk);
    value = 5'(v);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s busy_after_start", tag), int'(busy) | int'(done), 1);
    if (done) c = 1;
    else wait_done(c);
    check($sformatf("%s latency", tag), c, elat);
    check($sformatf("%s n", tag), int'(n), en);
    check($sformatf("%s found", tag), int'(found), ef);
    check($sformatf("%s busy_at_done", tag), int'(busy), 0);
    @(negedge clk);
    check($sformatf("%s done_pulse_width", tag), int'(done), 0);
  endtask

  vec_t vecs[$];
  int   c, pulses, en, ef, elat, v;
  int   fgen[8];

  initial begin
    CLR = 1'b1; start = 1'b0; value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset n", int'(n), 0);
    check("reset found", int'(found), 0);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    CLR = 1'b0;

    vecs.push_back('{1, 0, 1, 1});
    vecs.push_back('{2, 2, 1, 3});
    vecs.push_back('{3, 3, 1, 4});
    vecs.push_back('{5, 4, 1, 5});
    vecs.push_back('{8, 5, 1, 6});
    vecs.push_back('{13, 6, 1, 7});
    vecs.push_back('{21, 7, 1, 8});
    vecs.push_back('{4, 0, 0, 5});
    vecs.push_back('{0, 0, 0, 1});
    vecs.push_back('{22, 0, 0, 8});
    vecs.push_back('{6, 0, 0, 6});
    vecs.push_back('{31, 0, 0, 8});
    foreach (vecs[i])
      do_search(vecs[i].v, vecs[i].en, vecs[i].ef, vecs[i].elat, $sformatf("vec%0d_v%0d", i, vecs[i].v));

    // Start and value changes mid-search must not disturb the running search.
    @(negedge clk);
    value = 5'd21; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; value = 5'd2;
    wait_done(c);
    start = 1'b0;
    check("ignore latency", c, 7);
    check("ignore n", int'(n), 7);
    check("ignore found", int'(found), 1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a search.
    @(negedge clk);
    value = 5'd21; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    CLR = 1'b1;
    @(negedge clk);
    CLR = 1'b0;
    check("clr busy", int'(busy), 0);
    check("clr done", int'(done), 0);
    check("clr found", int'(found), 0);
    check("clr n", int'(n), 0);
    do_search(3, 3, 1, 4, "after_clr");

    // Start held high relaunches on every IDLE cycle: done on cycles 1, 4, 7.
    @(negedge clk);
    value = 5'd1; start = 1'b1;
    @(posedge clk);
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        pulses++;
        check($sformatf("held done_cycle_%0d", pulses), (i - 1) % 3, 0);
      end
    end
    start = 1'b0;
    check("held pulses", pulses, 3);
    repeat (3) @(negedge clk);

    // Loopback with generator output.
    fgen[0] = 1; fgen[1] = 1;
    for (int i = 2; i < 8; i++) fgen[i] = fgen[i-1] + fgen[i-2];
    for (int i = 0; i < 8; i++)
      do_search(fgen[i], (i == 1) ? 0 : i, 1, (i == 1) ? 1 : i + 1, $sformatf("loop_n%0d", i));

    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 31));
      ref_model(v, en, ef, elat);
      do_search(v, en, ef, elat, $sformatf("rand%0d_v%0d", i, v));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
